// File: rtl/hex_display_scheduler_pkg.sv
// Shared types and constants for the display scheduler and its digit decoder.
// Segment vectors are [0:6] with bit 0 = segment a and bit 6 = segment g, active high.
package hex_display_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SHOW = 2'd1,
        GAP  = 2'd2
    } state_e;

    typedef logic [0:6] seg_t;

    localparam int   NUM_DIGITS = 4;
    localparam seg_t SEG_BLANK  = 7'b0000000;

    localparam seg_t SEG_LUT [16] = '{
        7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
        7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
        7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
        7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
    };

endpackage

// File: rtl/hex_display_scheduler_seg7_nibble.sv
// Hex nibble to seven-segment pattern decoder.
// Latency: combinational; the scheduler registers the result.
// Backpressure: none, pure function of the input nibble.
module seg7_nibble
    import hex_display_pkg::*;
(
    input  logic [3:0] nib_i,
    output logic [0:6] seg_o
);

    assign seg_o = SEG_LUT[nib_i];

endmodule

// File: rtl/hex_display_scheduler.sv
// Round-robin owner of the four-digit display; define HEX_DISPLAY_SCHEDULER_SRCID_EN to show the source id on HEX3.
// Latency: request sampled at t -> grant and digits valid at t+1; every output comes straight from a flop.
// Backpressure: pause freezes dwell and arbitration; dropping the granted request releases the display next cycle.
module hex_display_scheduler
    import hex_display_pkg::*;
#(
    parameter int NSRC  = 4,
    parameter int DWELL = 50_000_000
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [NSRC-1:0]      src_req,
    input  logic [NSRC*16-1:0]   src_data,
    input  logic                 pause,
    output logic [NSRC-1:0]      src_gnt,
    output logic [2:0]           cur_src,
    output logic [0:6]           HEX3,
    output logic [0:6]           HEX2,
    output logic [0:6]           HEX1,
    output logic [0:6]           HEX0
);

    localparam int            CW       = (DWELL > 2) ? $clog2(DWELL) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(DWELL - 1);
`ifdef HEX_DISPLAY_SCHEDULER_SRCID_EN
    localparam int            SHW      = 12;
`else
    localparam int            SHW      = 16;
`endif

    state_e          state_q;
    logic [NSRC-1:0] gnt_q;
    logic [2:0]      cur_src_q;
    logic [2:0]      last_gnt_q;
    logic [SHW-1:0]  shadow_q;
    logic [SHW-1:0]  shadow_d;
    logic [CW-1:0]   cnt_q;
    seg_t            hex_q [NUM_DIGITS];

    logic [2:0]      win_idx;
    logic [NSRC-1:0] win_oh;
    logic [15:0]     win_data;
    int              arb_dist;
    int              arb_best;
    logic            grant_go;
    logic            cur_req;
    logic [3:0]      nib [NUM_DIGITS];
    seg_t            dec [NUM_DIGITS];

    // Distance from last_gnt+1 (mod NSRC); the closest requester wins.
    always_comb begin
        win_idx  = '0;
        win_oh   = '0;
        win_data = '0;
        arb_best = NSRC;
        arb_dist = 0;
        for (int j = 0; j < NSRC; j++) begin
            arb_dist = (j + NSRC - 1 - int'(last_gnt_q)) % NSRC;
            if (src_req[j] && (arb_dist < arb_best)) begin
                arb_best  = arb_dist;
                win_idx   = 3'(j);
                win_oh    = '0;
                win_oh[j] = 1'b1;
                win_data  = src_data[j*16 +: 16];
            end
        end
    end

    assign cur_req  = |(src_req & gnt_q);
    assign grant_go = (state_q != SHOW) && !pause && (|src_req);
    assign shadow_d = grant_go ? win_data[SHW-1:0] : shadow_q;

    always_comb begin
        nib[0] = shadow_d[3:0];
        nib[1] = shadow_d[7:4];
        nib[2] = shadow_d[11:8];
`ifdef HEX_DISPLAY_SCHEDULER_SRCID_EN
        nib[3] = {1'b0, win_idx};
`else
        nib[3] = shadow_d[15:12];
`endif
    end

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dig
        seg7_nibble u_dig (
            .nib_i (nib[g]),
            .seg_o (dec[g])
        );
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            gnt_q      <= '0;
            cur_src_q  <= '0;
            last_gnt_q <= 3'(NSRC - 1);
            shadow_q   <= '0;
            cnt_q      <= '0;
            for (int k = 0; k < NUM_DIGITS; k++) hex_q[k] <= SEG_BLANK;
        end else begin
            shadow_q <= shadow_d;
            case (state_q)
                IDLE, GAP: begin
                    if (grant_go) begin
                        state_q    <= SHOW;
                        gnt_q      <= win_oh;
                        cur_src_q  <= win_idx;
                        last_gnt_q <= win_idx;
                        cnt_q      <= CNT_LOAD;
                        for (int k = 0; k < NUM_DIGITS; k++) hex_q[k] <= dec[k];
                    end else if (!pause) begin
                        state_q <= IDLE;
                    end
                end
                SHOW: begin
                    // Release is honoured even while paused; only the dwell count freezes.
                    if (!cur_req || (!pause && (cnt_q == '0))) begin
                        state_q   <= GAP;
                        gnt_q     <= '0;
                        cur_src_q <= '0;
                        for (int k = 0; k < NUM_DIGITS; k++) hex_q[k] <= SEG_BLANK;
                    end else if (!pause) begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign src_gnt = gnt_q;
    assign cur_src = cur_src_q;
    assign HEX3    = hex_q[3];
    assign HEX2    = hex_q[2];
    assign HEX1    = hex_q[1];
    assign HEX0    = hex_q[0];

endmodule

// File: tb/tb_hex_display_scheduler.sv
// Randomized and directed bench for hex_display_scheduler against a cycle-level behavioural model.
module tb_hex_display_scheduler;

    localparam int NSRC = 4;
    localparam int DW   = 4;

    localparam logic [6:0] SEG_TAB [16] = '{
        7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
        7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
        7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
        7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
    };

    logic                 clk = 1'b0;
    logic                 reset_n;
    logic [NSRC-1:0]      src_req;
    logic [NSRC*16-1:0]   src_data;
    logic                 pause;
    logic [NSRC-1:0]      src_gnt;
    logic [2:0]           cur_src;
    logic [0:6]           HEX3, HEX2, HEX1, HEX0;
    logic [15:0]          data_arr [NSRC];

    int errors = 0;
    int checks = 0;

    // Behavioural model: which source is on screen, how many cycles it still owns, who went last.
    int          m_shown;
    int          m_left;
    int          m_last;
    logic [15:0] m_data;

    always_comb begin
        src_data = '0;
        for (int j = 0; j < NSRC; j++) src_data[j*16 +: 16] = data_arr[j];
    end

    always #5 clk = ~clk;

    hex_display_scheduler #(.NSRC(NSRC), .DWELL(DW)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .src_req  (src_req),
        .src_data (src_data),
        .pause    (pause),
        .src_gnt  (src_gnt),
        .cur_src  (cur_src),
        .HEX3     (HEX3),
        .HEX2     (HEX2),
        .HEX1     (HEX1),
        .HEX0     (HEX0)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_shown = -1;
        m_left  = 0;
        m_last  = NSRC - 1;
        m_data  = '0;
    endtask

    task automatic model_step();
        if (m_shown >= 0) begin
            if (!src_req[m_shown] || (!pause && m_left == 1)) m_shown = -1;
            else if (!pause) m_left--;
        end else if (!pause && src_req != '0) begin
            for (int k = 1; k <= NSRC; k++) begin
                if (src_req[(m_last + k) % NSRC]) begin
                    m_shown = (m_last + k) % NSRC;
                    break;
                end
            end
            m_last = m_shown;
            m_data = data_arr[m_shown];
            m_left = DW;
        end
    endtask

    function automatic logic [6:0] exp_hex(input int d);
        if (m_shown < 0) return 7'b0000000;
`ifdef HEX_DISPLAY_SCHEDULER_SRCID_EN
        if (d == 3) return SEG_TAB[m_shown];
`endif
        return SEG_TAB[m_data[4*d +: 4]];
    endfunction

    task automatic compare_model();
        check("gnt",  src_gnt, (m_shown >= 0) ? (32'd1 << m_shown) : 32'd0);
        check("cur",  cur_src, (m_shown >= 0) ? m_shown : 0);
        check("hex3", HEX3, exp_hex(3));
        check("hex2", HEX2, exp_hex(2));
        check("hex1", HEX1, exp_hex(1));
        check("hex0", HEX0, exp_hex(0));
    endtask

    task automatic step();
        @(posedge clk);
        if (!reset_n) model_reset();
        else model_step();
        #1;
        compare_model();
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        #1;
        model_reset();
        step();
        reset_n = 1'b1;
    endtask

    initial begin
        int order[$];
        int runs[$];
        int gaps[$];
        int len;
        int prev_idx;
        int gap_len;

        reset_n = 1'b0;
        src_req = '0;
        pause   = 1'b0;
        for (int j = 0; j < NSRC; j++) data_arr[j] = '0;
        model_reset();
        #2;
        check("rst_gnt",  src_gnt, 0);
        check("rst_cur",  cur_src, 0);
        check("rst_hex3", HEX3, 0);
        check("rst_hex0", HEX0, 0);
        step();
        step();
        reset_n = 1'b1;

        // Lone requester with 1234: explicit digits, then GAP and re-grant via the model.
        data_arr[0] = 16'h1234;
        src_req     = 4'b0001;
        step();
        check("s1_gnt", src_gnt, 4'b0001);
`ifdef HEX_DISPLAY_SCHEDULER_SRCID_EN
        check("s1_hex3", HEX3, 7'b1111110);
`else
        check("s1_hex3", HEX3, 7'b0110000);
`endif
        check("s1_hex2", HEX2, 7'b1101101);
        check("s1_hex1", HEX1, 7'b1111001);
        check("s1_hex0", HEX0, 7'b0110011);
        repeat (12) step();

        // All requesting: order 0,1,2,3,0, each run DW cycles, one-cycle gaps.
        src_req = '0;
        do_reset();
        for (int j = 0; j < NSRC; j++) data_arr[j] = 16'($urandom);
        src_req  = 4'b1111;
        prev_idx = -1;
        len      = 0;
        gap_len  = 0;
        for (int c = 0; c < 30; c++) begin
            step();
            if (src_gnt != '0) begin
                if (len == 0) begin
                    for (int j = 0; j < NSRC; j++) if (src_gnt[j]) order.push_back(j);
                    if (gap_len != 0) gaps.push_back(gap_len);
                    gap_len = 0;
                end
                len++;
            end else begin
                if (len != 0) runs.push_back(len);
                len = 0;
                gap_len++;
            end
        end
        for (int k = 0; k < 5; k++)
            check("s3_order", (order.size() > k) ? order[k] : -1, k % NSRC);
        for (int k = 0; k < 4; k++)
            check("s3_runlen", (runs.size() > k) ? runs[k] : -1, DW);
        for (int k = 0; k < 3; k++)
            check("s3_gaplen", (gaps.size() > k) ? gaps[k] : -1, 1);

        // Data change mid-dwell must not reach the display.
        src_req = '0;
        do_reset();
        data_arr[2] = 16'hABCD;
        src_req     = 4'b0100;
        step();
        step();
        data_arr[2] = 16'h0000;
        for (int c = 0; c < DW - 2; c++) begin
            step();
`ifdef HEX_DISPLAY_SCHEDULER_SRCID_EN
            check("s4_hex3", HEX3, 7'b1101101);
`else
            check("s4_hex3", HEX3, 7'b1110111);
`endif
            check("s4_hex2", HEX2, 7'b0011111);
            check("s4_hex1", HEX1, 7'b1001110);
            check("s4_hex0", HEX0, 7'b0111101);
        end
        repeat (4) step();

        // Early release by source 1 hands over to source 2 after one blank cycle.
        src_req = '0;
        do_reset();
        data_arr[1] = 16'h1111;
        data_arr[2] = 16'h2222;
        src_req     = 4'b0110;
        step();
        check("s5_gnt1", src_gnt, 4'b0010);
        step();
        src_req = 4'b0100;
        step();
        check("s5_rel_gnt",  src_gnt, 0);
        check("s5_rel_hex0", HEX0, 0);
        step();
        check("s5_gnt2", src_gnt, 4'b0100);

        // Five pause cycles stretch a DW-cycle grant to DW+5.
        src_req = '0;
        do_reset();
        src_req = 4'b0001;
        step();
        len = (src_gnt != '0) ? 1 : 0;
        step();
        if (src_gnt != '0) len++;
        pause = 1'b1;
        repeat (5) begin
            step();
            if (src_gnt != '0) len++;
        end
        pause = 1'b0;
        for (int c = 0; c < 20; c++) begin
            step();
            if (src_gnt == '0) break;
            len++;
        end
        check("s6_len", len, DW + 5);

        // Asynchronous reset in the middle of source 3's grant.
        src_req = '0;
        do_reset();
        data_arr[3] = 16'h3333;
        src_req     = 4'b1000;
        step();
        step();
        check("s7_pre_gnt", src_gnt, 4'b1000);
        reset_n = 1'b0;
        #1;
        check("s7_async_gnt",  src_gnt, 0);
        check("s7_async_cur",  cur_src, 0);
        check("s7_async_hex3", HEX3, 0);
        check("s7_async_hex0", HEX0, 0);
        model_reset();
        step();
        step();
        data_arr[0] = 16'h5A5A;
        src_req     = 4'b1111;
        reset_n     = 1'b1;
        step();
        check("s7_first_gnt", src_gnt, 4'b0001);
`ifdef HEX_DISPLAY_SCHEDULER_SRCID_EN
        check("s7_hex3", HEX3, 7'b1111110);
`else
        check("s7_hex3", HEX3, 7'b1011011);
`endif
        repeat (6) step();

        // Random traffic against the model.
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 3) == 0) src_req = NSRC'($urandom);
            data_arr[$urandom_range(0, NSRC - 1)] = 16'($urandom);
            pause = ($urandom_range(0, 9) == 0);
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/hex_display_scheduler.md
# hex_display_scheduler

Round-robin scheduler that shares the four-digit seven-segment display (HEX3..HEX0) among up to NSRC requesting datapath blocks. Each requester asks for display time with a req/gnt handshake. The granted source's 16-bit value is latched and shown as four hex digits for a fixed dwell time, then the display is handed to the next requester. It sits between datapath debug/result ports and the board display pins, and instantiates one per-digit decoder four times.

## Interface
- NSRC, 4: number of requesters, 2..8.
- DWELL, 50_000_000: display cycles per grant, ≥ 2.
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- src_req  in  NSRC  per-source request, level.
- src_data  in  NSRC×16  per-source value; sampled only at grant.
- pause  in  1  freezes dwell counter and arbitration; display holds.
- src_gnt  out  NSRC  one-hot grant; all-zero when no source is shown.
- cur_src  out  3  index of shown source; 0 when idle.
- HEX3, HEX2, HEX1, HEX0  out  [0:6] each  segment drive, active-high, bit 0 = segment a … bit 6 = segment g.

## Operation
- States: IDLE, SHOW, GAP.
- **IDLE**: all HEX blank (7'b0000000), src_gnt = 0. If any src_req is set and pause = 0, arbitrate → SHOW.
- **Arbitration**:
  - Round-robin, searching from last_gnt+1 upward, wrapping at NSRC-1 → 0.
  - last_gnt resets to NSRC-1, so source 0 wins first.
  - Winner: latch src_data into shadow register, set src_gnt one-hot, update cur_src and last_gnt, load dwell counter = DWELL-1.
- **SHOW**:
  - Digits show the shadow register: HEX3 = [15:12], HEX2 = [11:8], HEX1 = [7:4], HEX0 = [3:0].
  - Counter decrements each cycle unless pause = 1.
  - At count 0 → GAP.
  - If the granted source drops src_req, go → GAP on the next cycle (early release).
- **GAP**: one cycle, all HEX blank, src_gnt = 0. Then arbitrate as in IDLE. If there is no request → IDLE.
- A lone requester is re-granted after each GAP, and its data is re-latched.
- src_data changes during SHOW have no effect on the display.
- pause = 1 in IDLE or GAP blocks arbitration. The FSM stays in its state; GAP holds until pause = 0.
- Digit encoding (hex 0–F): 0 = 1111110, 1 = 0110000, 2 = 1101101, 3 = 1111001, 4 = 0110011, 5 = 1011011, 6 = 1011111, 7 = 1110000, 8 = 1111111, 9 = 1111011, A = 1110111, b = 0011111, C = 1001110, d = 0111101, E = 1001111, F = 1000111.

## Timing
- All outputs registered.
- Reset values: state IDLE, src_gnt = 0, cur_src = 0, all HEX = 0000000, shadow = 0, counter = 0, last_gnt = NSRC-1.
- Grant latency: src_req sampled high in cycle t → src_gnt and the digits valid at t+1.
- A grant lasts exactly DWELL cycles with pause low, each extra pause cycle extends it by one. GAP adds one blank cycle.
- Early release: req low at t → gnt low and display blank at t+1.
- Simultaneous expiry and req drop → single GAP.
- reset_n asserted mid-SHOW: outputs blank immediately (asynchronous), grant lost; after release the first grant goes to source 0.

## Configuration
- Macro: HEX_DISPLAY_SCHEDULER_SRCID_EN.
- Defined:
  - HEX3 shows cur_src as a hex digit during SHOW.
  - Only src_data[11:0] is shown, on HEX2..HEX0.
  - The shadow register is 12 bits.
- Undefined: all 16 bits are shown as above.

## Structure
- Package hex_display_pkg holds:
  - state enum (IDLE, SHOW, GAP);
  - SEG_BLANK constant;
  - the 16-entry segment lookup constant;
  - the digit-count constant.
- Sub-module seg7_nibble: combinational 4-bit → [0:6] decoder using the package lookup. Instantiated ×4; its outputs are registered in the scheduler.

## Test plan
- Reset, then src_req = 0001, src_data[0] = 16'h1234, DWELL = 4 → gnt = 0001 one cycle later; HEX3..0 = 0110000, 1101101, 1111001, 0110011 for 4 cycles; blank GAP; re-grant.
- src_req = 1111 held, DWELL = 3 → grant order 0, 1, 2, 3, 0. Each grant lasts 3 cycles, separated by a 1-cycle blank.
- Source 2 granted with data 16'hABCD; src_data[2] changes to 16'h0000 mid-dwell → display stays A, b, C, d until expiry.
- Source 1 granted; src_req[1] dropped after 2 of 8 cycles → next cycle gnt = 0, display blank, then source 2 is granted if requesting.
- pause = 1 for 5 cycles mid-SHOW with DWELL = 4 → the grant lasts 9 cycles.
- reset_n pulsed low mid-SHOW of source 3 → all HEX = 0000000 and gnt = 0 asynchronously. With all requests high afterwards, source 0 is granted first. With HEX_DISPLAY_SCHEDULER_SRCID_EN defined, HEX3 = 1111110 for source 0.
